// File: rtl/tt_sweep_if.sv
// Bus bundle between a truth-table sweeper and its driver.
// Handshake: start is a level request with no ready; the sweeper takes it
// only while busy is low and it is idle, otherwise start is simply ignored.
// done is a one-cycle completion pulse; valid and match stay meaningful
// from that pulse until the next sweep is accepted.
interface tt_sweep_if;
  logic       start;
  logic [7:0] expected;
  logic       dut_out;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       busy;
  logic       done;
  logic [7:0] truth_table;
  logic       valid;
  logic       match;

  modport master (
    output start, expected, dut_out,
    input  in1, in2, in3, busy, done, truth_table, valid, match
  );

  modport slave (
    input  start, expected, dut_out,
    output in1, in2, in3, busy, done, truth_table, valid, match
  );
endinterface

// File: rtl/tt_sweep.sv
// Truth-table sweeper for a 3-input gate: drives codes 0..7 in order, holds
// each for SETTLE_CYCLES cycles, samples the gate output, then compares the
// captured table with the reference table in a one-cycle DONE state.
module tt_sweep #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  tt_sweep_if.slave   bus,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] in_q, in_d;
  logic [7:0] tt_q, tt_d;
  logic       valid_q, valid_d;
  logic       match_q, match_d;
  logic       cmp_now;

  // expected is only looked at while in DONE
  assign cmp_now = (tt_q == bus.expected);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers; reset discards any partial sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= 3'd0;
      cnt_q   <= 8'd0;
      in_q    <= 3'd0;
      tt_q    <= 8'h00;
      valid_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      tt_q    <= tt_d;
      valid_q <= valid_d;
      match_q <= match_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
      S_SAMPLE: state_d = (idx_q == 3'd7) ? S_DONE : S_SETTLE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values: code stepping, settle counting, capture, result latch
  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    valid_d = valid_q;
    match_d = match_q;
    in_d    = 3'd0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          idx_d   = 3'd0;
          cnt_d   = 8'd0;
          tt_d    = 8'h00;
          valid_d = 1'b0;
          match_d = 1'b0;
        end
      end
      S_SETTLE: cnt_d = cnt_q + 8'd1;
      S_SAMPLE: begin
        // inputs still hold code idx at this edge, so the capture is aligned
        tt_d[idx_q] = bus.dut_out;
        if (idx_q == 3'd7) begin
          valid_d = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
          cnt_d = 8'd0;
        end
      end
      S_DONE:   match_d = cmp_now;
      default:  ;
    endcase
    // gate inputs carry the code only while a sweep is driving it
    if (state_d == S_SETTLE || state_d == S_SAMPLE) in_d = idx_d;
  end

  // Output decode
  always_comb begin
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    bus.match = match_q;
    case (state_q)
      S_SETTLE, S_SAMPLE: bus.busy = 1'b1;
      S_DONE: begin
        bus.done  = 1'b1;
        bus.match = cmp_now;
      end
      default: ;
    endcase
  end

  assign bus.in1         = in_q[0];
  assign bus.in2         = in_q[1];
  assign bus.in3         = in_q[2];
  assign bus.truth_table = tt_q;
  assign bus.valid       = valid_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_tt_sweep.sv
// Bench for tt_sweep: three instances (SETTLE_CYCLES = 1, 2, 3) share clk/rst.
// A cycle-index reference model predicts every output each cycle; directed
// sweeps add literal expectations, then a randomized phase runs all three.
module tb_tt_sweep;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  logic       start_a [3];
  logic [7:0] exp_a   [3];
  logic [7:0] fsel    [3];
  logic       dly_en  [3];
  logic       dout_a  [3];
  logic [2:0] code_a  [3];
  logic       busy_a  [3];
  logic       done_a  [3];
  logic       valid_a [3];
  logic       match_a [3];
  logic [7:0] tt_a    [3];
  logic [1:0] st_a    [3];

  // DUT instances with their gate models (truth function fsel, optional 2-stage delay)
  for (genvar g = 0; g < 3; g++) begin : g_dut
    tt_sweep_if ifc ();
    logic d1 = 1'b0;
    logic d2 = 1'b0;

    assign ifc.start    = start_a[g];
    assign ifc.expected = exp_a[g];
    assign code_a[g]    = {ifc.in3, ifc.in2, ifc.in1};
    assign dout_a[g]    = dly_en[g] ? d2 : fsel[g][code_a[g]];
    assign ifc.dut_out  = dout_a[g];
    assign busy_a[g]    = ifc.busy;
    assign done_a[g]    = ifc.done;
    assign valid_a[g]   = ifc.valid;
    assign match_a[g]   = ifc.match;
    assign tt_a[g]      = ifc.truth_table;

    always @(posedge clk) begin
      d1 <= fsel[g][code_a[g]];
      d2 <= d1;
    end

    tt_sweep #(.SETTLE_CYCLES(g + 1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (ifc),
      .state_dbg (st_a[g])
    );
  end

  // Reference model: t counts cycles since the accepting edge (1-based).
  // Each code occupies S+1 cycles; the last of them is the sampling cycle.
  int         m_t     [3];
  bit         m_run   [3];
  logic [7:0] m_cap   [3];
  logic [7:0] m_tt    [3];
  logic       m_valid [3];
  logic       m_match [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_run[i]   <= 1'b0;
        m_t[i]     <= 0;
        m_cap[i]   <= 8'h00;
        m_tt[i]    <= 8'h00;
        m_valid[i] <= 1'b0;
        m_match[i] <= 1'b0;
      end else if (m_run[i]) begin
        if (m_t[i] <= 8 * (i + 2)) begin
          if ((m_t[i] - 1) % (i + 2) == i + 1)
            m_cap[i][(m_t[i] - 1) / (i + 2)] <= dout_a[i];
          m_t[i] <= m_t[i] + 1;
        end else begin
          m_tt[i]    <= m_cap[i];
          m_valid[i] <= 1'b1;
          m_match[i] <= (m_cap[i] == exp_a[i]);
          m_run[i]   <= 1'b0;
        end
      end else if (start_a[i]) begin
        m_run[i]   <= 1'b1;
        m_t[i]     <= 1;
        m_cap[i]   <= 8'h00;
        m_tt[i]    <= 8'h00;
        m_valid[i] <= 1'b0;
        m_match[i] <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s[%0d] at %0t: got 0x%0h, expected 0x%0h", nm, inst, $time, act, exp);
    end
  endtask

  // Per-cycle compare of every instance against the model
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int i = 0; i < 3; i++) begin
          int len;
          logic e_busy, e_done, e_valid, e_match;
          logic [2:0] e_code;
          logic [7:0] e_tt;
          len = 8 * (i + 2);
          if (m_run[i] && m_t[i] <= len) begin
            e_busy = 1'b1; e_done = 1'b0; e_code = 3'((m_t[i] - 1) / (i + 2));
            e_tt = m_cap[i]; e_valid = 1'b0; e_match = 1'b0;
          end else if (m_run[i]) begin
            e_busy = 1'b0; e_done = 1'b1; e_code = 3'd0;
            e_tt = m_cap[i]; e_valid = 1'b1; e_match = (m_cap[i] == exp_a[i]);
          end else begin
            e_busy = 1'b0; e_done = 1'b0; e_code = 3'd0;
            e_tt = m_tt[i]; e_valid = m_valid[i]; e_match = m_match[i];
          end
          chk("busy", i, 32'(busy_a[i]), 32'(e_busy));
          chk("done", i, 32'(done_a[i]), 32'(e_done));
          chk("inputs", i, 32'(code_a[i]), 32'(e_code));
          chk("truth_table", i, 32'(tt_a[i]), 32'(e_tt));
          chk("valid", i, 32'(valid_a[i]), 32'(e_valid));
          chk("match", i, 32'(match_a[i]), 32'(e_match));
        end
      end
    end
  endtask

  // One directed sweep on instance i with literal expectations
  task automatic sweep(input int i, input logic [7:0] fs, input logic dl, input logic [7:0] ex,
                       input bit repulse, input int exp_lat, input logic [7:0] exp_tt,
                       input logic exp_match);
    int first_done = -1;
    int done_cnt = 0;
    int busy_bad = 0;
    int seq_bad = 0;
    int nseq = 0;
    int k = 0;
    @(posedge clk); #1;
    fsel[i] = fs; dly_en[i] = dl; exp_a[i] = ex; start_a[i] = 1'b1;
    @(posedge clk); #1;
    start_a[i] = 1'b0;
    while (k <= 100 && (first_done < 0 || k <= first_done + 10)) begin
      @(negedge clk);
      if (done_a[i] === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
      if (first_done < 0) begin
        if (busy_a[i] !== 1'b1) busy_bad++;
        if (code_a[i] !== 3'(nseq / (i + 2))) seq_bad++;
        nseq++;
      end
      @(posedge clk); #1;
      k++;
      start_a[i] = (repulse && (k == 5 || k == 20)) ? 1'b1 : 1'b0;
      if (k == 3) exp_a[i] = ~ex;
      if (k == exp_lat - 1) exp_a[i] = ex;
    end
    @(negedge clk);
    chk("latency", i, 32'(first_done), 32'(exp_lat));
    chk("done_pulses", i, 32'(done_cnt), 32'd1);
    chk("busy_low_in_sweep", i, 32'(busy_bad), 32'd0);
    chk("code_sequence", i, 32'(seq_bad), 32'd0);
    chk("sweep_length", i, 32'(nseq), 32'(exp_lat));
    chk("final_tt", i, 32'(tt_a[i]), 32'(exp_tt));
    chk("model_tt", i, 32'(m_tt[i]), 32'(exp_tt));
    chk("final_valid", i, 32'(valid_a[i]), 32'd1);
    chk("final_match", i, 32'(match_a[i]), 32'(exp_match));
  endtask

  initial begin
    int w;
    int hold [3];
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0; exp_a[i] = 8'h00; fsel[i] = 8'h80; dly_en[i] = 1'b0; hold[i] = 0;
    end
    fork
      compare_loop();
    join_none

    // clock/reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_tt", i, 32'(tt_a[i]), 32'h00);
      chk("reset_busy", i, 32'(busy_a[i]), 32'd0);
    end

    // AND3 gate, S=2: 24-cycle latency, table 0x80
    sweep(1, 8'h80, 1'b0, 8'h80, 1'b0, 24, 8'h80, 1'b1);
    // Output stuck at 1: full table, no match
    sweep(1, 8'hFF, 1'b0, 8'h80, 1'b0, 24, 8'hFF, 1'b0);
    // S=1: 16-cycle latency, each code held two cycles
    sweep(0, 8'h80, 1'b0, 8'h80, 1'b0, 16, 8'h80, 1'b1);
    // Extra start pulses mid-sweep are ignored
    sweep(1, 8'h80, 1'b0, 8'h80, 1'b1, 24, 8'h80, 1'b1);

    // Reset in the middle of a sweep at code 3, partial table is discarded
    @(posedge clk); #1;
    fsel[1] = 8'hFF; dly_en[1] = 1'b0; start_a[1] = 1'b1;
    @(posedge clk); #1;
    start_a[1] = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (code_a[1] !== 3'd3 && w < 100);
    chk("reached_code3", 1, 32'(code_a[1]), 32'd3);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 1, 32'(busy_a[1]), 32'd0);
    chk("rst_done", 1, 32'(done_a[1]), 32'd0);
    chk("rst_inputs", 1, 32'(code_a[1]), 32'd0);
    chk("rst_tt", 1, 32'(tt_a[1]), 32'h00);
    chk("rst_valid", 1, 32'(valid_a[1]), 32'd0);
    chk("rst_match", 1, 32'(match_a[1]), 32'd0);
    sweep(1, 8'h80, 1'b0, 8'h80, 1'b0, 24, 8'h80, 1'b1);

    // Gate with two register stages of delay, S=3 settles long enough
    sweep(2, 8'h80, 1'b1, 8'h80, 1'b0, 32, 8'h80, 1'b1);

    // Randomized phase: random gate functions, references, starts (incl. long holds), resets
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 3; i++) begin
        if (hold[i] > 0) begin
          start_a[i] = 1'b1;
          hold[i]--;
        end else if ($urandom_range(0, 63) == 0) begin
          hold[i] = $urandom_range(20, 80);
          start_a[i] = 1'b1;
        end else begin
          start_a[i] = ($urandom_range(0, 15) == 0);
        end
        if ($urandom_range(0, 7) == 0) begin
          fsel[i] = 8'($urandom);
          exp_a[i] = ($urandom_range(0, 1) == 1) ? fsel[i] : 8'($urandom);
        end
        if ($urandom_range(0, 31) == 0) dly_en[i] = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) start_a[i] = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tt_sweep.md
TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, meaning cycles each input combination is held before sampling; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to begin a sweep; accepted only in IDLE.
REQ-005 The block SHALL have port expected, input, 8, the reference truth table; bit i is the expected output for input code i.
REQ-006 The block SHALL have port dut_out, input, 1, the output of the 3-input logic gate under test.
REQ-007 The block SHALL have ports in1, in2 and in3, output, 1 each, the gate inputs, registered; {in3,in2,in1} equals the current code.
REQ-008 The block SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse at sweep completion.
REQ-010 The block SHALL have port truth_table, output, 8, the captured gate outputs; bit i holds dut_out sampled while code i was driven.
REQ-011 The block SHALL have port valid, output, 1, high when truth_table and match hold a completed sweep.
REQ-012 The block SHALL have port match, output, 1, high when truth_table equals expected at completion.

Function
REQ-013 The block SHALL implement states IDLE, SETTLE, SAMPLE and DONE, with a 3-bit code index idx and an 8-bit settle counter cnt.
REQ-014 IDLE with start=1 SHALL make these changes at the next edge: state to SETTLE; idx and cnt to 0; truth_table, valid and match to 0; busy to 1.
REQ-015 In SETTLE, {in3,in2,in1} SHALL equal idx and cnt SHALL increment each cycle.
REQ-016 The SETTLE-to-SAMPLE transition SHALL occur at the edge where cnt==SETTLE_CYCLES-1, so that SETTLE lasts exactly SETTLE_CYCLES cycles.
REQ-017 In SAMPLE, truth_table[idx] SHALL load dut_out at the cycle-ending edge while the inputs still hold code idx.
REQ-018 SAMPLE with idx<7 SHALL, at the next edge, increment idx, clear cnt and return to SETTLE.
REQ-019 SAMPLE with idx==7 SHALL go to DONE.
REQ-020 Codes SHALL be swept in order 0,1,...,7 with no skips or repeats; idx SHALL never wrap within a sweep.
REQ-021 DONE SHALL last exactly one cycle: done=1 and busy=0 during that cycle; valid=1 and match=(truth_table==expected) from that cycle; then IDLE.
REQ-022 done SHALL be first high 8*(SETTLE_CYCLES+1) cycles after the edge that accepted start.
REQ-023 In IDLE and DONE, in1, in2 and in3 SHALL be 0.
REQ-024 In IDLE, truth_table, valid and match SHALL hold their values until the next accepted start.
REQ-025 A start asserted in SETTLE, SAMPLE or DONE SHALL be ignored, with no queuing and no effect on the sweep in progress.
REQ-026 expected SHALL be sampled only in the DONE cycle; changes during a sweep SHALL have no effect.
REQ-027 A start held continuously high SHALL begin a new sweep on the first IDLE cycle after DONE.

Reset
REQ-028 When rst=1 at an edge, the block SHALL enter IDLE with idx=0, cnt=0, in1=in2=in3=0, busy=0, done=0, valid=0, match=0 and truth_table=8'h00.
REQ-029 rst SHALL take priority over start and over every state transition, including in the middle of a sweep; a partial truth_table SHALL be discarded.
REQ-030 After rst deasserts, the first accepted start SHALL run a complete sweep that is unaffected by the aborted one.

Verification
REQ-031 The bench SHALL cover: dut_out = in1&in2&in3, expected=8'h80, SETTLE_CYCLES=2 -> truth_table=8'h80, match=1, valid=1, done pulse exactly 24 cycles after start is accepted.
REQ-032 The bench SHALL cover: dut_out tied to 1, expected=8'h80 -> truth_table=8'hFF, match=0, valid=1.
REQ-033 The bench SHALL cover: SETTLE_CYCLES=1 with an AND3 model -> done pulse at 16 cycles; {in3,in2,in1} observed as 0..7, each held for 2 cycles.
REQ-034 The bench SHALL cover: start re-pulsed at sweep cycles 5 and 20 -> ignored; done pulses once and busy stays high throughout.
REQ-035 The bench SHALL cover: rst pulsed while idx==3 -> next cycle all outputs 0 and state IDLE; a following start yields a correct 8'h80 sweep.
REQ-036 The bench SHALL cover: dut_out = AND3 delayed by 2 register stages, SETTLE_CYCLES=3 -> truth_table=8'h80, match=1.
